udp_txbuf_writer: RTL and testbench
===================================

// Module: udp_txbuf_writer
// PURPOSE
//  Writer side of the UDP TX buffer shared between the CPU and the ROS2 IP. Accepts one UDP payload
//  as an 8-bit stream, packs bytes into 32-bit words, writes words into udp_txbuf, then a header.
//  Pulses txbuf_rel to hand the buffer to the IP, which reads and transmits it.
//  Sits between a CPU/host byte-stream source and the txbuf grant arbiter.
// PARAMETERS
//  AWIDTH     9   udp_txbuf word-address width; payload capacity MAXB = (2**AWIDTH-2)*4 bytes
// PORTS
//  clk              in   1       system clock
//  rst_n            in   1       asynchronous, active-low reset
//  enable           in   1       block enable; low = synchronous abort to IDLE
//  s_tdata          in   8       payload byte
//  s_tvalid         in   1       byte valid
//  s_tready         out  1       byte accepted when tvalid&tready
//  s_tlast          in   1       last payload byte
//  hdr_dest_ip      in   32      destination IP, sampled with first byte
//  hdr_dest_port    in   16      destination UDP port, sampled with first byte
//  txbuf_grant      in   1       buffer owned by this writer (arbiter CPU grant)
//  txbuf_rel        out  1       1-cycle release pulse to arbiter
//  txbuf_addr       out  AWIDTH  word address
//  txbuf_ce         out  1       buffer access enable
//  txbuf_we         out  1       write enable (always equals txbuf_ce)
//  txbuf_wdata      out  32      write data
//  pkt_done         out  1       1-cycle pulse: packet committed and released
//  pkt_err          out  1       1-cycle pulse: packet exceeded MAXB and was dropped
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, byte count 0. Assertion mid-packet discards it with no rel.
//  Buffer layout: word0={len[15:0],dest_port[15:0]}, word1=dest_ip, word 2+k/4 holds byte k in
//  bits [8*(k%4)+7 : 8*(k%4)] (little-endian). Unused bytes of the last word are written as 0.
//  All txbuf outputs are registered. len = bytes accepted (1..MAXB, 16 bits).
//  FSM:
//   IDLE   s_tready=0. grant & tvalid & enable -> DATA; latch hdr_dest_ip and hdr_dest_port.
//   DATA   s_tready=1, 1 byte/cycle. On the 4th byte of a word, write the word the next cycle.
//          On tlast, write the partial or full word the next cycle -> HDR_LEN.
//          An accepted byte with count==MAXB and no tlast -> DRAIN; no further writes.
//   DRAIN  s_tready=1, discard bytes; on tlast pulse pkt_err -> IDLE. No header write, no rel,
//          grant kept.
//   HDR_LEN write word0 -> HDR_IP; HDR_IP write word1 -> REL.
//          Header is written last, so len is never valid before the payload.
//   REL    txbuf_rel=1 and pkt_done=1 for one cycle -> WAIT_UNGRANT.
//   WAIT_UNGRANT  s_tready=0 until txbuf_grant==0 -> IDLE. Prevents restart on stale grant.
//  Latency: tlast accepted at t -> last data write t+1, word0 t+2, word1 t+3, rel t+4.
//  Exactly MAXB bytes with tlast on the last byte is legal and is not an error.
//  Grant dropping outside WAIT_UNGRANT is an arbiter protocol violation: the FSM ignores it and
//  verification flags it.
//  enable low in any state: next cycle IDLE, counters cleared, no write, rel, done or err.
//  A write already registered completes.
// STRUCTURE
//  Shared package/header (config.vh): state encodings, TXBUF_HDR_WORDS=2, header field offsets.
//  The IP-side reader uses the same layout. No sub-module; byte packer and FSM sit in one always
//  block plus a registered write port.
// TESTING
//  1. grant=1, stream 5 bytes 01..05, port 0x1F90, ip 0xC0A80101 -> word2=0x04030201,
//     word3=0x00000005, word0=0x00051F90, word1=0xC0A80101, rel at tlast+4, pkt_done.
//  2. grant=0 with tvalid=1 -> s_tready=0, no ce; raise grant -> transfer starts next cycle.
//  3. AWIDTH=3 (MAXB=24): 24 bytes with tlast -> committed, len=24. 30 bytes -> pkt_err at
//     byte 30, no rel, no writes after word 7.
//  4. Random tvalid gaps (50%) on a 64-byte packet -> buffer contents identical to gap-free run.
//  5. rst_n low mid-DATA -> outputs 0 asynchronously; after release, next packet writes from
//     word2 and len counts only the new bytes.
//  6. After rel, hold grant high 3 cycles, then low -> no new accept until grant cycles low
//     and back to high.

Source files
------------

// File: rtl/udp_txbuf_writer_pkg.sv
// Shared definitions for the UDP TX buffer writer: FSM encoding and buffer layout.
package udp_txbuf_writer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE         = 3'd0,
    ST_DATA         = 3'd1,
    ST_DRAIN        = 3'd2,
    ST_HDR_LEN      = 3'd3,
    ST_HDR_IP       = 3'd4,
    ST_REL          = 3'd5,
    ST_WAIT_UNGRANT = 3'd6
  } state_e;

  // Header occupies the first words; payload starts right after it.
  localparam int TXBUF_HDR_WORDS = 2;
  localparam int HDR_LEN_WORD    = 0;
  localparam int HDR_IP_WORD     = 1;
  // Field offsets inside header word 0.
  localparam int HDR_LEN_LSB     = 16;
  localparam int HDR_PORT_LSB    = 0;

  // Payload capacity in bytes for a buffer of 2**awidth words.
  function automatic int payload_max_bytes(input int awidth);
    return ((1 << awidth) - TXBUF_HDR_WORDS) * 4;
  endfunction

endpackage

// File: rtl/udp_txbuf_writer.sv
// Writer side of the shared UDP TX buffer: packs an 8-bit payload stream into
// little-endian 32-bit words, writes the header last, then releases the buffer.
//
// Stream handshake: a byte transfers on a rising clk edge where s_tvalid and
// s_tready are both high; s_tlast marks the final byte of the payload.
module udp_txbuf_writer
  import udp_txbuf_writer_pkg::*;
#(
  parameter int AWIDTH = 9
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic [7:0]        s_tdata,
  input  logic              s_tvalid,
  output logic              s_tready,
  input  logic              s_tlast,
  input  logic [31:0]       hdr_dest_ip,
  input  logic [15:0]       hdr_dest_port,
  input  logic              txbuf_grant,
  output logic              txbuf_rel,
  output logic [AWIDTH-1:0] txbuf_addr,
  output logic              txbuf_ce,
  output logic              txbuf_we,
  output logic [31:0]       txbuf_wdata,
  output logic              pkt_done,
  output logic              pkt_err,
  output state_e            dbg_state
);

  localparam int          MAXB   = payload_max_bytes(AWIDTH);
  localparam logic [15:0] MAXB_W = 16'(MAXB);

  state_e            state, state_nx;
  logic [15:0]       cnt;
  logic [31:0]       pack;
  logic [31:0]       dest_ip;
  logic [15:0]       dest_port;

  logic              accept;
  logic              start;
  logic              overflow;
  logic [1:0]        lane;
  logic [31:0]       pack_nx;

  logic              ce_nx;
  logic [AWIDTH-1:0] addr_nx;
  logic [31:0]       wdata_nx;
  logic              rel_nx;
  logic              done_nx;
  logic              err_nx;

  assign lane      = cnt[1:0];
  assign s_tready  = enable & ((state == ST_DATA) | (state == ST_DRAIN));
  assign accept    = s_tvalid & s_tready;
  assign start     = (state == ST_IDLE) & enable & txbuf_grant & s_tvalid;
  // A byte arriving when the buffer already holds MAXB bytes cannot be stored.
  assign overflow  = (state == ST_DATA) & accept & (cnt == MAXB_W);
  // Unused upper lanes stay zero because pack is cleared after every word write.
  assign pack_nx   = pack | (32'(s_tdata) << {lane, 3'b000});
  assign dbg_state = state;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  // Next state and next values of the registered buffer/status outputs.
  always_comb begin
    state_nx = state;
    ce_nx    = 1'b0;
    addr_nx  = '0;
    wdata_nx = '0;
    rel_nx   = 1'b0;
    done_nx  = 1'b0;
    err_nx   = 1'b0;
    if (!enable) begin
      state_nx = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: if (start) state_nx = ST_DATA;
        ST_DATA: begin
          if (overflow) begin
            if (s_tlast) begin
              err_nx   = 1'b1;
              state_nx = ST_IDLE;
            end else begin
              state_nx = ST_DRAIN;
            end
          end else if (accept) begin
            if ((lane == 2'd3) || s_tlast) begin
              ce_nx    = 1'b1;
              addr_nx  = AWIDTH'(TXBUF_HDR_WORDS) + AWIDTH'(cnt >> 2);
              wdata_nx = pack_nx;
            end
            if (s_tlast) state_nx = ST_HDR_LEN;
          end
        end
        ST_DRAIN: begin
          if (accept && s_tlast) begin
            err_nx   = 1'b1;
            state_nx = ST_IDLE;
          end
        end
        ST_HDR_LEN: begin
          ce_nx                            = 1'b1;
          addr_nx                          = AWIDTH'(HDR_LEN_WORD);
          wdata_nx[HDR_LEN_LSB +: 16]      = cnt;
          wdata_nx[HDR_PORT_LSB +: 16]     = dest_port;
          state_nx                         = ST_HDR_IP;
        end
        ST_HDR_IP: begin
          ce_nx    = 1'b1;
          addr_nx  = AWIDTH'(HDR_IP_WORD);
          wdata_nx = dest_ip;
          state_nx = ST_REL;
        end
        ST_REL: begin
          rel_nx   = 1'b1;
          done_nx  = 1'b1;
          state_nx = ST_WAIT_UNGRANT;
        end
        ST_WAIT_UNGRANT: if (!txbuf_grant) state_nx = ST_IDLE;
        default: state_nx = ST_IDLE;
      endcase
    end
  end

  // Byte counter, word packer and header latch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      pack      <= '0;
      dest_ip   <= '0;
      dest_port <= '0;
    end else if (!enable) begin
      cnt  <= '0;
      pack <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          cnt  <= '0;
          pack <= '0;
          if (start) begin
            dest_ip   <= hdr_dest_ip;
            dest_port <= hdr_dest_port;
          end
        end
        ST_DATA: begin
          if (accept && !overflow) begin
            cnt  <= cnt + 16'd1;
            pack <= ((lane == 2'd3) || s_tlast) ? '0 : pack_nx;
          end
        end
        default: ;
      endcase
    end
  end

  // Registered buffer port and status pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      txbuf_ce    <= 1'b0;
      txbuf_we    <= 1'b0;
      txbuf_addr  <= '0;
      txbuf_wdata <= '0;
      txbuf_rel   <= 1'b0;
      pkt_done    <= 1'b0;
      pkt_err     <= 1'b0;
    end else begin
      txbuf_ce    <= ce_nx;
      txbuf_we    <= ce_nx;
      txbuf_addr  <= addr_nx;
      txbuf_wdata <= wdata_nx;
      txbuf_rel   <= rel_nx;
      pkt_done    <= done_nx;
      pkt_err     <= err_nx;
    end
  end

endmodule

// File: tb/tb_udp_txbuf_writer.sv
// Bench for udp_txbuf_writer: a reference model pushes the expected buffer
// writes and release/error events; a monitor pops and compares them.
module tb_udp_txbuf_writer;
  import udp_txbuf_writer_pkg::*;

  localparam int AW   = 5;
  localparam int MAXB = ((1 << AW) - 2) * 4;   // 120 payload bytes
  localparam int EW   = AW + 34;
  localparam logic [1:0] K_WR  = 2'd0;
  localparam logic [1:0] K_REL = 2'd1;
  localparam logic [1:0] K_ERR = 2'd2;

  // clock / reset block
  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b0;
  logic [7:0]    s_tdata = '0;
  logic          s_tvalid = 1'b0;
  logic          s_tready;
  logic          s_tlast = 1'b0;
  logic [31:0]   hdr_dest_ip = '0;
  logic [15:0]   hdr_dest_port = '0;
  logic          txbuf_grant = 1'b0;
  logic          txbuf_rel;
  logic [AW-1:0] txbuf_addr;
  logic          txbuf_ce;
  logic          txbuf_we;
  logic [31:0]   txbuf_wdata;
  logic          pkt_done;
  logic          pkt_err;
  state_e        dbg_state;

  int cyc = 0;
  int tlast_cyc = 0;
  int checks = 0;
  int errors = 0;
  logic [EW-1:0] exp_q[$];
  logic [7:0]    payload [0:255];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  udp_txbuf_writer #(.AWIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tlast(s_tlast),
    .hdr_dest_ip(hdr_dest_ip), .hdr_dest_port(hdr_dest_port),
    .txbuf_grant(txbuf_grant), .txbuf_rel(txbuf_rel), .txbuf_addr(txbuf_addr),
    .txbuf_ce(txbuf_ce), .txbuf_we(txbuf_we), .txbuf_wdata(txbuf_wdata),
    .pkt_done(pkt_done), .pkt_err(pkt_err), .dbg_state(dbg_state)
  );

  function automatic logic [EW-1:0] ev(input logic [1:0] k, input int a, input logic [31:0] d);
    logic [AW-1:0] aa;
    aa = a[AW-1:0];
    return {k, aa, d};
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", name, got, want);
    end
  endtask

  // reference model: what the buffer must receive for an n-byte payload
  task automatic expect_pkt(input int n, input logic [15:0] port, input logic [31:0] ip);
    int kept;
    logic [31:0] word;
    kept = (n > MAXB) ? MAXB : n;
    for (int w = 0; w * 4 < kept; w++) begin
      word = '0;
      for (int b = 0; b < 4; b++)
        if (w * 4 + b < kept) word[8*b +: 8] = payload[w*4+b];
      exp_q.push_back(ev(K_WR, 2 + w, word));
    end
    if (n > MAXB) begin
      exp_q.push_back(ev(K_ERR, 0, '0));
    end else begin
      exp_q.push_back(ev(K_WR, 0, {n[15:0], port}));
      exp_q.push_back(ev(K_WR, 1, ip));
      exp_q.push_back(ev(K_REL, 0, '0));
    end
  endtask

  // interrupted payload: only the words completed so far are written
  task automatic expect_partial(input int n);
    logic [31:0] word;
    for (int w = 0; w < n / 4; w++) begin
      word = {payload[w*4+3], payload[w*4+2], payload[w*4+1], payload[w*4]};
      exp_q.push_back(ev(K_WR, 2 + w, word));
    end
  endtask

  task automatic gen_payload(input int n);
    for (int i = 0; i < n; i++) payload[i] = 8'($urandom);
  endtask

  // driver: called and returns at a falling edge
  task automatic send_bytes(input int n, input int gap, input bit with_last);
    int g;
    for (int i = 0; i < n; i++) begin
      if (gap > 0 && $urandom_range(99) < gap) begin
        s_tvalid = 1'b0;
        repeat ($urandom_range(1, 3)) @(negedge clk);
      end
      s_tdata  = payload[i];
      s_tlast  = with_last && (i == n - 1);
      s_tvalid = 1'b1;
      g = 0;
      while (!s_tready && g < 100) begin
        @(negedge clk);
        g++;
      end
      if (!s_tready) begin
        checks++;
        errors++;
        $display("FAIL byte_accept_timeout byte=%0d tready=%b required=1", i, s_tready);
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        return;
      end
      if (s_tlast) tlast_cyc = cyc;
      @(negedge clk);
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic wait_queue();
    int g;
    g = 0;
    while (exp_q.size() != 0 && g < 600) begin
      @(negedge clk);
      g++;
    end
    chk("queue_drained", exp_q.size(), 0);
    exp_q.delete();
    @(negedge clk);
  endtask

  task automatic cycle_grant();
    txbuf_grant = 1'b0;
    @(negedge clk);
    txbuf_grant = 1'b1;
  endtask

  task automatic set_hdr();
    hdr_dest_ip   = $urandom;
    hdr_dest_port = 16'($urandom);
  endtask

  // scoreboard monitor
  task automatic monitor();
    logic [EW-1:0] got, want;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (txbuf_ce || txbuf_we) chk("we_equals_ce", txbuf_we, txbuf_ce);
        if (txbuf_ce || txbuf_rel || pkt_done || pkt_err) begin
          if (txbuf_ce)     got = ev(K_WR, int'(txbuf_addr), txbuf_wdata);
          else if (pkt_err) got = ev(K_ERR, 0, '0);
          else              got = ev(K_REL, 0, '0);
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_output got=%h required=none", got);
          end else begin
            want = exp_q.pop_front();
            chk("scoreboard", got, want);
          end
        end
        if (txbuf_rel || pkt_done) begin
          chk("rel_equals_done", txbuf_rel, pkt_done);
          chk("rel_latency", cyc - tlast_cyc, 4);
        end
        if (pkt_err) chk("err_latency", cyc - tlast_cyc, 1);
      end
    end
  endtask

  task automatic run();
    int n;
    // reset state
    #3;
    chk("rst_tready", s_tready, 0);
    chk("rst_ce", txbuf_ce, 0);
    chk("rst_we", txbuf_we, 0);
    chk("rst_addr", txbuf_addr, 0);
    chk("rst_wdata", txbuf_wdata, 0);
    chk("rst_rel", txbuf_rel, 0);
    chk("rst_done", pkt_done, 0);
    chk("rst_err", pkt_err, 0);
    repeat (3) @(negedge clk);
    rst_n  = 1'b1;
    enable = 1'b1;
    @(negedge clk);

    // no grant: byte offered but never taken
    for (int i = 0; i < 5; i++) payload[i] = 8'(i + 1);
    hdr_dest_port = 16'h1F90;
    hdr_dest_ip   = 32'hC0A80101;
    s_tdata  = payload[0];
    s_tvalid = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("nogrant_tready", s_tready, 0);
      chk("nogrant_ce", txbuf_ce, 0);
    end
    txbuf_grant = 1'b1;
    chk("grant_edge_tready", s_tready, 0);
    @(negedge clk);
    chk("grant_next_tready", s_tready, 1);

    // known-answer packet
    exp_q.push_back(ev(K_WR, 2, 32'h04030201));
    exp_q.push_back(ev(K_WR, 3, 32'h00000005));
    exp_q.push_back(ev(K_WR, 0, 32'h00051F90));
    exp_q.push_back(ev(K_WR, 1, 32'hC0A80101));
    exp_q.push_back(ev(K_REL, 0, '0));
    send_bytes(5, 0, 1'b1);
    wait_queue();

    // stale grant after release must not restart a transfer
    gen_payload(64);
    set_hdr();
    expect_pkt(64, hdr_dest_port, hdr_dest_ip);
    s_tdata  = payload[0];
    s_tvalid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("stale_grant_tready", s_tready, 0);
    end
    txbuf_grant = 1'b0;
    @(negedge clk);
    chk("ungrant_tready", s_tready, 0);
    txbuf_grant = 1'b1;
    send_bytes(64, 0, 1'b1);
    wait_queue();
    cycle_grant();

    // same 64-byte payload with random gaps
    expect_pkt(64, hdr_dest_port, hdr_dest_ip);
    send_bytes(64, 50, 1'b1);
    wait_queue();
    cycle_grant();

    // capacity boundaries: exact fit, one over with tlast, several over
    for (int t = 0; t < 3; t++) begin
      n = (t == 0) ? MAXB : (t == 1) ? MAXB + 1 : MAXB + 6;
      gen_payload(n);
      set_hdr();
      expect_pkt(n, hdr_dest_port, hdr_dest_ip);
      send_bytes(n, 10, 1'b1);
      wait_queue();
      if (n <= MAXB) cycle_grant();
    end

    // asynchronous reset while a data word is on the port
    gen_payload(8);
    set_hdr();
    expect_partial(8);
    send_bytes(8, 0, 1'b0);
    chk("pre_reset_tready", s_tready, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_ce", txbuf_ce, 0);
    chk("async_rst_we", txbuf_we, 0);
    chk("async_rst_wdata", txbuf_wdata, 0);
    chk("async_rst_addr", txbuf_addr, 0);
    chk("async_rst_tready", s_tready, 0);
    chk("async_rst_queue", exp_q.size(), 0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    gen_payload(6);
    set_hdr();
    expect_pkt(6, hdr_dest_port, hdr_dest_ip);
    send_bytes(6, 0, 1'b1);
    wait_queue();
    cycle_grant();

    // enable low mid-payload aborts without header or release
    gen_payload(6);
    set_hdr();
    expect_partial(6);
    send_bytes(6, 0, 1'b0);
    enable = 1'b0;
    @(negedge clk);
    enable = 1'b1;
    gen_payload(3);
    set_hdr();
    s_tdata  = payload[0];
    s_tvalid = 1'b1;
    chk("abort_idle_tready", s_tready, 0);
    expect_pkt(3, hdr_dest_port, hdr_dest_ip);
    send_bytes(3, 0, 1'b1);
    wait_queue();
    cycle_grant();

    // random packets
    for (int p = 0; p < 12; p++) begin
      n = ($urandom_range(5) == 0) ? $urandom_range(MAXB + 1, MAXB + 8) : $urandom_range(1, MAXB);
      gen_payload(n);
      set_hdr();
      expect_pkt(n, hdr_dest_port, hdr_dest_ip);
      send_bytes(n, $urandom_range(0, 60), 1'b1);
      wait_queue();
      if (n <= MAXB) cycle_grant();
    end
  endtask

  initial begin
    fork
      monitor();
    join_none
    run();
    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
